bram_frame_reader: RTL

- Read side of the receiver's ping-pong sample buffer in BRAM.
- The write-side address counter drives `start`, a level that toggles each time one half of the buffer fills. This block detects each toggle and reads back the half that just completed.
- Words are streamed out on an AXI-Stream master with full backpressure. The last word of each half is flagged with `m_tlast`.
- Sits between the capture BRAM (port B) and the downstream DMA/processing chain.

---
 rtl/bram_frame_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bram_frame_reader.sv
// Read side of the ping-pong capture buffer: each toggle of start reads back the
// half that just filled and streams it out on an AXI-Stream master.
module bram_frame_reader #(
  parameter int POS_DIG    = 2,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [31:0]       bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              lost
);

  localparam int HALF = 1 << POS_DIG;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [POS_DIG-1:0] LAST_CNT = {POS_DIG{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_start_q;
  logic               r_armed;
  logic [31:0]        r_base;
  logic [31:0]        w_base_nxt;
  logic [POS_DIG-1:0] r_rd_cnt;
  logic [POS_DIG-1:0] w_rd_cnt_nxt;
  logic [RD_LAT-1:0]  r_pv;
  logic [RD_LAT-1:0]  r_pl;
  logic [DATA_W:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_done;
  logic               r_lost;
  logic [CW:0]        w_in_flight;
  logic               w_edge;
  logic               w_issue;
  logic               w_credit;
  logic               w_push;
  logic               w_pop;
  logic               w_last_hs;

  // r_armed keeps the first cycle after reset from seeing a bogus edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= start;
      r_armed   <= 1'b1;
    end
  end

  assign w_edge = r_armed & (start ^ r_start_q);

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_in_flight = w_in_flight + (CW+1)'(r_pv[i]);
    end
  end

  // Reads already launched count against FIFO space so the FIFO can never overflow.
  assign w_credit = (w_in_flight + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_rd_cnt_nxt = r_rd_cnt;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_base_nxt   = start ? 32'd0 : 32'(HALF);
          w_rd_cnt_nxt = '0;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue      = 1'b1;
          w_rd_cnt_nxt = r_rd_cnt + POS_DIG'(1);
          if (r_rd_cnt == LAST_CNT) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_last_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_base   <= 32'd0;
      r_rd_cnt <= '0;
      r_done   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_base   <= w_base_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_done   <= w_last_hs;
      r_lost   <= r_lost | (w_edge & (r_state != IDLE));
    end
  end

  assign bram_en   = w_issue;
  assign bram_addr = w_issue ? (r_base + 32'(r_rd_cnt)) : 32'd0;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign lost      = r_lost;

  // Valid/last bits travel alongside the BRAM latency so data is caught exactly when it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      r_pl <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue & (r_rd_cnt == LAST_CNT);
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
  end

  assign w_push    = r_pv[RD_LAT-1];
  assign m_tvalid  = (r_count != '0);
  assign w_pop     = m_tvalid & m_tready;
  assign m_tdata   = m_tvalid ? r_mem[r_rptr][DATA_W-1:0] : '0;
  assign m_tlast   = m_tvalid & r_mem[r_rptr][DATA_W];
  assign w_last_hs = (r_state == DRAIN) & w_pop & m_tlast;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_pl[RD_LAT-1], bram_dout};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
